alu_slice_seq: RTL and testbench
================================

Name: alu_slice_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 16-bit ripple adder/flag unit.
- Processes a WIDTH-bit operation one SLICE-bit chunk per clock, carrying between chunks in a register.
- Adds subtract, carry-chained ops (ADC/SBB) and logic ops.
- Uses valid/ready handshakes on both sides, so it can sit between a register-file read stage and a writeback stage.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; NSLICE = WIDTH/SLICE (≥1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  3  000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 AND, 101 OR, 110 XOR, 111 PASS (z=x).
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- z  output  WIDTH  result.
- sign  output  1  z[WIDTH-1].
- carry  output  1  carry flag.
- overflow  output  1  signed overflow.
- parity  output  1  1 when z has an even number of ones (XNOR-reduce).
- zero  output  1  1 when z == 0.

Behaviour:
- States are IDLE, RUN, DONE.
- in_ready = (state==IDLE), combinational from state, so it reads 1 while in reset.
- Reset (async, rst_n=0):
  - state=IDLE, slice counter=0.
  - z=0; sign, carry, overflow, parity, zero=0; out_valid=0.
  - Internal carry flag CF=0.
- Accept (IDLE, in_valid=1):
  - Latch op, x, y; counter=0.
  - Load slice carry-in: ADD=0, SUB=1, ADC=CF, SBB=CF; logic ops don't care.
  - Go to RUN.
- RUN, one slice k (bits [k*SLICE +: SLICE]) per cycle:
  - ADD/ADC: z_k = x_k + y_k + c.
  - SUB/SBB: z_k = x_k + ~y_k + c.
  - Logic ops apply bitwise to the slice.
  - Slice carry-out is registered as c for slice k+1.
  - After slice NSLICE-1, go to DONE and assert out_valid.
- Latency: accept edge at cycle 0; out_valid is high after the NSLICE-th following edge, i.e. NSLICE cycles of RUN.
- Flags are registered when entering DONE:
  - Arithmetic ops:
    - carry = final carry-out. For SUB/SBB, carry=1 means no borrow.
    - overflow = (a_msb==b_msb) & (z_msb!=a_msb), where b = y for ADD/ADC and ~y for SUB/SBB.
  - Logic/PASS ops: carry=0, overflow=0.
  - All ops: sign, parity and zero are computed from the final z.
  - CF is updated to the carry flag for every op; logic ops clear CF.
- DONE:
  - z and flags are held stable while out_valid=1 and out_ready=0.
  - in_valid is ignored; no new request is accepted.
  - On out_ready=1, out_valid drops on the next edge and state returns to IDLE; in_ready rises the cycle after the output handshake (no overlap).
  - Maximum throughput is one operation per NSLICE+2 cycles.
- z and flags keep their last value outside DONE (not cleared); only out_valid qualifies them.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted, all registers return to reset values, and the result is never presented.
- NSLICE=1 degenerates to a 1-cycle RUN; this must work.
- op values are decoded only at accept, so later changes on op/x/y have no effect.

Test Plan (WIDTH=16, SLICE=4 unless noted):
1. ADD x=0x7FFF y=0x0001 -> z=0x8000, sign=1, carry=0, overflow=1, parity=0, zero=0; out_valid exactly 4 edges after the accept edge.
2. ADD 0xFFFF+0x0001 -> z=0x0000, carry=1, zero=1, parity=1, overflow=0; then ADC 0x0000+0x0000 -> z=0x0001, carry=0 (CF chained).
3. SUB 0x0003-0x0005 -> z=0xFFFE, carry=0, sign=1, overflow=0, parity=0; SUB 0x0005-0x0003 -> z=0x0002, carry=1; SUB 0x8000-0x0001 -> z=0x7FFF, overflow=1.
4. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new x/y -> z and flags unchanged, in_ready=0, no accept; raise out_ready -> in_ready=1 on the following cycle.
5. Reset pulse during RUN slice 2 -> out_valid=0, all flags 0, in_ready=1 immediately; after release, ADC 0x0001+0x0001 -> z=0x0002 (CF was cleared).
6. XOR 0xAAAA^0x5555 -> z=0xFFFF, parity=1, carry=0, overflow=0, sign=1; repeat test 1 with WIDTH=32, SLICE=8 and with WIDTH=8, SLICE=8 (NSLICE=1) for matching width-scaled results.

Source files
------------

// File: rtl/alu_slice_seq.sv
// alu_slice_seq: multi-cycle ALU that works through a WIDTH-bit operation
// SLICE bits per clock. The carry between slices lives in a register, and a
// sticky carry flag (CF) chains ADC/SBB across separate operations.
// Both sides use a valid/ready handshake. A new request is accepted only in
// IDLE, so operations never overlap.
module alu_slice_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             carry,
    output logic             overflow,
    output logic             parity,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    // Keep the counter at least one bit wide so NSLICE=1 still elaborates.
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_PAS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             c_q;        // carry into the current slice
    logic [WIDTH-1:0] acc_q;      // result being assembled slice by slice
    logic             cf_q;       // carry flag kept across operations
    logic [WIDTH-1:0] z_q;
    logic             sign_q;
    logic             carry_q;
    logic             ovf_q;
    logic             parity_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [SLICE-1:0] xs;
    logic [SLICE-1:0] ys;
    logic [SLICE-1:0] bs;
    logic [SLICE:0]   sum;
    logic [SLICE-1:0] rs;
    logic [WIDTH-1:0] acc_d;
    logic             arith;
    logic             sub;
    logic             bmsb;
    logic             carry_d;
    logic             ovf_d;
    logic             cin_d;

    // Handshake outputs are a function of state and the registered valid.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign sign      = sign_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign parity    = parity_q;
    assign zero      = zero_q;

    // Carry into slice 0: ADD starts at 0, SUB at 1 (two's complement).
    // ADC and SBB chain the previous CF. Logic ops ignore the value.
    always_comb begin
        cin_d = cf_q;
        if (op == OP_ADD) cin_d = 1'b0;
        else if (op == OP_SUB) cin_d = 1'b1;
    end

    // One slice of the datapath, plus the flags the final slice produces.
    always_comb begin
        xs    = '0;
        ys    = '0;
        acc_d = acc_q;
        for (int k = 0; k < NSLICE; k++) begin
            if (cnt_q == CW'(k)) begin
                xs = x_q[k*SLICE +: SLICE];
                ys = y_q[k*SLICE +: SLICE];
            end
        end
        sub   = op_q[1];
        arith = ~op_q[2];
        bs    = sub ? ~ys : ys;
        sum   = {1'b0, xs} + {1'b0, bs} + {{SLICE{1'b0}}, c_q};
        case (op_q)
            OP_AND:  rs = xs & ys;
            OP_OR:   rs = xs | ys;
            OP_XOR:  rs = xs ^ ys;
            OP_PAS:  rs = xs;
            default: rs = sum[SLICE-1:0];
        endcase
        for (int k = 0; k < NSLICE; k++) begin
            if (cnt_q == CW'(k)) acc_d[k*SLICE +: SLICE] = rs;
        end
        // Overflow looks at the effective B operand, which is ~y when subtracting.
        bmsb    = y_q[WIDTH-1] ^ sub;
        carry_d = arith & sum[SLICE];
        ovf_d   = arith & (x_q[WIDTH-1] == bmsb) & (acc_d[WIDTH-1] != x_q[WIDTH-1]);
    end

    // Control FSM. The result and flags are registered on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            c_q         <= 1'b0;
            acc_q       <= '0;
            cf_q        <= 1'b0;
            z_q         <= '0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            parity_q    <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= op;
                        x_q     <= x;
                        y_q     <= y;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        c_q     <= cin_d;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    c_q   <= sum[SLICE];
                    if (cnt_q == LAST) begin
                        z_q         <= acc_d;
                        sign_q      <= acc_d[WIDTH-1];
                        carry_q     <= carry_d;
                        ovf_q       <= ovf_d;
                        parity_q    <= ~^acc_d;
                        zero_q      <= (acc_d == '0);
                        cf_q        <= carry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Bench for alu_slice_seq. It uses three instances: 16/4 as the main unit,
// 32/8, and 8/8 (a single slice). Expected results come from a full-width
// reference model. They are queued when a request is accepted and popped
// when out_valid appears.
module tb_alu_slice_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic iv0, or0, rdy0, ov0, s0, c0, v0, p0, zr0;
    logic [2:0] op0;
    logic [15:0] x0, y0, z0;
    logic iv1, or1, rdy1, ov1, s1, c1, v1, p1, zr1;
    logic [2:0] op1;
    logic [31:0] x1, y1, z1;
    logic iv2, or2, rdy2, ov2, s2, c2, v2, p2, zr2;
    logic [2:0] op2;
    logic [7:0] x2, y2, z2;

    alu_slice_seq #(.WIDTH(16), .SLICE(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0), .op(op0),
        .x(x0), .y(y0), .out_valid(ov0), .out_ready(or0), .z(z0), .sign(s0),
        .carry(c0), .overflow(v0), .parity(p0), .zero(zr0));
    alu_slice_seq #(.WIDTH(32), .SLICE(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .op(op1),
        .x(x1), .y(y1), .out_valid(ov1), .out_ready(or1), .z(z1), .sign(s1),
        .carry(c1), .overflow(v1), .parity(p1), .zero(zr1));
    alu_slice_seq #(.WIDTH(8), .SLICE(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2), .op(op2),
        .x(x2), .y(y2), .out_valid(ov2), .out_ready(or2), .z(z2), .sign(s2),
        .carry(c2), .overflow(v2), .parity(p2), .zero(zr2));

    typedef struct packed {
        logic [31:0] z;
        logic s, c, v, p, zr;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    res_t last;
    logic cf_m[3];
    int   lat_of[3] = '{4, 4, 1};
    int   w_of[3]   = '{16, 32, 8};

    // Full-width reference: plain integer arithmetic, no slicing.
    function automatic res_t model(int w, logic [2:0] o, logic [31:0] a, logic [31:0] b, logic cfin);
        logic [63:0] mask, xm, ym, yb, s;
        logic cin;
        res_t r;
        mask = (64'd1 << w) - 64'd1;
        xm = {32'b0, a} & mask;
        ym = {32'b0, b} & mask;
        yb = o[1] ? (~ym & mask) : ym;
        cin = (o == 3'd0) ? 1'b0 : (o == 3'd2) ? 1'b1 : cfin;
        case (o)
            3'd4: s = xm & ym;
            3'd5: s = xm | ym;
            3'd6: s = xm ^ ym;
            3'd7: s = xm;
            default: s = xm + yb + {63'b0, cin};
        endcase
        r.z  = 32'(s & mask);
        r.c  = !o[2] && s[w];
        r.v  = !o[2] && (xm[w-1] == yb[w-1]) && (s[w-1] != xm[w-1]);
        r.s  = s[w-1];
        r.p  = ~^(s & mask);
        r.zr = ((s & mask) == 64'd0);
        return r;
    endfunction

    task automatic set_in(int d, logic v, logic [2:0] o, logic [31:0] a, logic [31:0] b);
        case (d)
            0: begin iv0 = v; op0 = o; x0 = a[15:0]; y0 = b[15:0]; end
            1: begin iv1 = v; op1 = o; x1 = a;       y1 = b;       end
            default: begin iv2 = v; op2 = o; x2 = a[7:0]; y2 = b[7:0]; end
        endcase
    endtask

    task automatic set_ordy(int d, logic r);
        case (d)
            0: or0 = r;
            1: or1 = r;
            default: or2 = r;
        endcase
    endtask

    function automatic logic get_rdy(int d);
        return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
    endfunction

    function automatic logic get_ov(int d);
        return (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
    endfunction

    function automatic res_t get_out(int d);
        res_t r;
        case (d)
            0: r = '{{16'b0, z0}, s0, c0, v0, p0, zr0};
            1: r = '{z1, s1, c1, v1, p1, zr1};
            default: r = '{{24'b0, z2}, s2, c2, v2, p2, zr2};
        endcase
        return r;
    endfunction

    // Wait for in_ready, present one request, and queue its expected result.
    task automatic issue(int d, logic [2:0] o, logic [31:0] a, logic [31:0] b);
        int n = 0;
        res_t e;
        @(negedge clk);
        while (!get_rdy(d) && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (!get_rdy(d)) begin
            errors++;
            $display("FAIL accept_wait dut%0d in_ready=0 expected 1", d);
        end
        e = model(w_of[d], o, a, b, cf_m[d]);
        sb.push_back(e);
        cf_m[d] = e.c;
        set_in(d, 1'b1, o, a, b);
        @(posedge clk);
        #1;
        // Scramble the inputs after accept. They must not affect the result.
        set_in(d, 1'b0, 3'($urandom), $urandom, $urandom);
    endtask

    // Wait for the result, then check latency and values.
    // Hold the result for 'hold' cycles, then do the output handshake.
    task automatic wait_result(int d, int hold);
        int n = 0;
        res_t got, exp;
        @(negedge clk);
        while (!get_ov(d) && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n != lat_of[d]) begin
            errors++;
            $display("FAIL latency dut%0d got %0d expected %0d", d, n, lat_of[d]);
        end
        got  = get_out(d);
        last = got;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty dut%0d got z=%h", d, got.z);
        end else begin
            exp = sb.pop_front();
            checks++;
            if (got.z !== exp.z) begin
                errors++;
                $display("FAIL z dut%0d got %h expected %h", d, got.z, exp.z);
            end
            checks++;
            if ({got.s, got.c, got.v, got.p, got.zr} !== {exp.s, exp.c, exp.v, exp.p, exp.zr}) begin
                errors++;
                $display("FAIL flags(s,c,v,p,z) dut%0d got %b expected %b", d,
                         {got.s, got.c, got.v, got.p, got.zr}, {exp.s, exp.c, exp.v, exp.p, exp.zr});
            end
        end
        for (int i = 0; i < hold; i++) begin
            set_in(d, 1'b1, 3'($urandom), $urandom, $urandom);
            @(negedge clk);
            checks++;
            if (!get_ov(d) || get_rdy(d) || get_out(d) !== got) begin
                errors++;
                $display("FAIL hold dut%0d cyc%0d ov=%b rdy=%b out=%h expected ov=1 rdy=0 out=%h",
                         d, i, get_ov(d), get_rdy(d), get_out(d), got);
            end
        end
        set_in(d, 1'b0, 3'd0, 32'd0, 32'd0);
        set_ordy(d, 1'b1);
        @(posedge clk);
        #1 set_ordy(d, 1'b0);
        @(negedge clk);
        checks++;
        if (get_ov(d) || !get_rdy(d)) begin
            errors++;
            $display("FAIL handshake dut%0d ov=%b rdy=%b expected ov=0 rdy=1", d, get_ov(d), get_rdy(d));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            set_in(d, 1'b0, 3'd0, 32'd0, 32'd0);
            set_ordy(d, 1'b0);
            cf_m[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_ov(d) !== 1'b0) begin errors++; $display("FAIL reset_ov dut%0d got %b expected 0", d, get_ov(d)); end
            checks++;
            if (get_rdy(d) !== 1'b1) begin errors++; $display("FAIL reset_rdy dut%0d got %b expected 1", d, get_rdy(d)); end
            checks++;
            if (get_out(d) !== '0) begin errors++; $display("FAIL reset_out dut%0d got %h expected 0", d, get_out(d)); end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        issue(0, 3'd0, 32'h7FFF, 32'h0001);
        wait_result(0, 0);
        checks++;
        if (last !== '{32'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_literal got %h expected z=8000 s=1 c=0 v=1 p=0 zr=0", last);
        end
    endtask

    task automatic test_carry_chain();
        issue(0, 3'd0, 32'hFFFF, 32'h0001);
        wait_result(0, 0);
        issue(0, 3'd1, 32'h0000, 32'h0000);
        wait_result(0, 0);
    endtask

    task automatic test_sub();
        issue(0, 3'd2, 32'h0003, 32'h0005); wait_result(0, 0);
        issue(0, 3'd2, 32'h0005, 32'h0003); wait_result(0, 0);
        issue(0, 3'd2, 32'h8000, 32'h0001); wait_result(0, 0);
        issue(0, 3'd3, 32'h1234, 32'h0234); wait_result(0, 0);
    endtask

    task automatic test_backpressure();
        issue(0, 3'd0, 32'h1357, 32'h2468);
        wait_result(0, 5);
    endtask

    task automatic test_reset_mid_run();
        issue(0, 3'd0, 32'hFFFF, 32'h0001);   // leaves CF=1 if it were to finish
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        for (int d = 0; d < 3; d++) cf_m[d] = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b0 || rdy0 !== 1'b1 || get_out(0) !== '0) begin
            errors++;
            $display("FAIL mid_reset ov=%b rdy=%b out=%h expected ov=0 rdy=1 out=0", ov0, rdy0, get_out(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ov0 !== 1'b0) begin errors++; $display("FAIL aborted_result cyc%0d ov=%b expected 0", i, ov0); end
        end
        issue(0, 3'd1, 32'h0001, 32'h0001);
        wait_result(0, 0);
    endtask

    task automatic test_logic();
        issue(0, 3'd6, 32'hAAAA, 32'h5555); wait_result(0, 0);
        issue(0, 3'd4, 32'hF0F0, 32'h0FF0); wait_result(0, 0);
        issue(0, 3'd5, 32'h0000, 32'h0000); wait_result(0, 0);
        issue(0, 3'd7, 32'hBEEF, 32'h1111); wait_result(0, 0);
        // Logic ops clear CF, so this ADC must not add a carry.
        issue(0, 3'd0, 32'hFFFF, 32'h0001); wait_result(0, 0);
        issue(0, 3'd5, 32'h0001, 32'h0000); wait_result(0, 0);
        issue(0, 3'd1, 32'h0001, 32'h0001); wait_result(0, 0);
    endtask

    task automatic test_widths();
        issue(1, 3'd0, 32'h7FFFFFFF, 32'h00000001); wait_result(1, 0);
        issue(2, 3'd0, 32'h7F, 32'h01);             wait_result(2, 0);
        issue(2, 3'd0, 32'hFF, 32'h01);             wait_result(2, 2);
        issue(2, 3'd1, 32'h10, 32'h20);             wait_result(2, 0);
        issue(1, 3'd3, 32'h00000000, 32'h00000001); wait_result(1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            int d;
            d = i % 3;
            issue(d, 3'($urandom), $urandom, $urandom);
            wait_result(d, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_logic();
        test_widths();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
